// File: rtl/hilo_pkg.sv
// hilo_pkg: shared definitions for the HI/LO multiply/divide sequencer.
//   - operation codes driven by the execute stage
//   - FSM state encoding
//   - datapath width and divider iteration count
//   - magnitude helper used when loading the divider
package hilo_pkg;

  localparam int DATA_W     = 32;
  localparam int DIV_CYCLES = 32;
  localparam int CNT_W      = $clog2(DIV_CYCLES);

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  // Codes 1..6 are real requests; NONE and the reserved code are ignored.
  function automatic logic op_valid(input logic [2:0] op);
    return (op != OP_NONE) && (op != OP_RSVD);
  endfunction

  // Absolute value for signed operands, raw value for unsigned ones.
  // 0x80000000 maps onto itself, which is exactly the unsigned magnitude.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] x,
                                                  input logic is_signed);
    return (is_signed && x[DATA_W-1]) ? -x : x;
  endfunction

endpackage

// File: rtl/hilo_if.sv
// hilo_if: request/result bundle between the execute stage and hilo_ctrl.
//   master (pipeline): start, op, a, b, hi_cur, lo_cur, flush -> ; <- busy, hilo_we, hi_o, lo_o
//   slave  (hilo_ctrl): the mirror image
interface hilo_if;
  import hilo_pkg::*;

  logic              start;
  logic [2:0]        op;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] hi_cur;
  logic [DATA_W-1:0] lo_cur;
  logic              flush;
  logic              busy;
  logic              hilo_we;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  modport master (
    output start, op, a, b, hi_cur, lo_cur, flush,
    input  busy, hilo_we, hi_o, lo_o
  );

  modport slave (
    input  start, op, a, b, hi_cur, lo_cur, flush,
    output busy, hilo_we, hi_o, lo_o
  );

endinterface

// File: rtl/hilo_divider.sv
// hilo_divider: unsigned restoring divider, one quotient bit per step.
//   clk, rst      : clock, asynchronous active-low reset
//   load          : capture dividend/divisor magnitudes, clear remainder, arm counter
//   step          : perform one shift/subtract iteration
//   dividend      : unsigned dividend magnitude
//   divisor       : unsigned divisor magnitude (never zero when loaded)
//   quo, rem      : quotient/remainder registers as they stand after the current step,
//                   so the controller can capture the final result on the last step's edge
//   done          : high during the step that completes the division
module hilo_divider
  import hilo_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quo,
  output logic [DATA_W-1:0] rem,
  output logic              done
);

  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] div_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W:0]   rem_sh;
  logic [DATA_W:0]   diff;

  // One restoring iteration. The dividend is shifted out of the quotient
  // register into the remainder; a borrow (diff MSB set) means the trial
  // subtraction is undone and a 0 quotient bit is shifted in.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    quo    = quo_q;
    rem    = rem_q;
    rem_sh = {rem_q, quo_q[DATA_W-1]};
    diff   = rem_sh - {1'b0, div_q};
    if (diff[DATA_W]) begin
      rem = rem_sh[DATA_W-1:0];
      quo = {quo_q[DATA_W-2:0], 1'b0};
    end else begin
      rem = diff[DATA_W-1:0];
      quo = {quo_q[DATA_W-2:0], 1'b1};
    end
  end

  assign done = step && (cnt_q == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quo_q <= '0;
      rem_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      div_q <= divisor;
      cnt_q <= CNT_W'(DIV_CYCLES - 1);
    end else if (step) begin
      quo_q <= quo;
      rem_q <= rem;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: multiply/divide sequencer owning all writes to the HI/LO pair.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : hilo_if.slave
//     start/op/a/b : request from execute (sampled only in IDLE)
//     hi_cur/lo_cur: current HI/LO, used to preserve the untouched half on MTHI/MTLO
//     flush        : cancels an in-flight MUL/DIV, drops a same-cycle request
//     busy         : pipeline stall, high while in MUL or DIV
//     hilo_we      : one-cycle write strobe, hi_o/lo_o valid with it
module hilo_ctrl
  import hilo_pkg::*;
(
  input logic   clk,
  input logic   rst,
  hilo_if.slave bus
);

  state_t              state;
  logic                busy_q;
  logic                we_q;
  logic [DATA_W-1:0]   hi_q;
  logic [DATA_W-1:0]   lo_q;
  logic [DATA_W-1:0]   mul_a;
  logic [DATA_W-1:0]   mul_b;
  logic                mul_signed;
  logic                sign_q;
  logic                sign_r;

  logic                accept;
  logic                div_signed;
  logic                div_load;
  logic                div_step;
  logic                div_done;
  logic [DATA_W-1:0]   div_dividend;
  logic [DATA_W-1:0]   div_divisor;
  logic [DATA_W-1:0]   div_quo;
  logic [DATA_W-1:0]   div_rem;
  logic [DATA_W-1:0]   quo_fin;
  logic [DATA_W-1:0]   rem_fin;
  logic [2*DATA_W-1:0] ext_a;
  logic [2*DATA_W-1:0] ext_b;
  logic [2*DATA_W-1:0] product;

  // flush beats a same-cycle request.
  assign accept = (state == ST_IDLE) && bus.start && !bus.flush && op_valid(bus.op);

  assign div_signed   = (bus.op == OP_DIV);
  assign div_dividend = magnitude(bus.a, div_signed);
  assign div_divisor  = magnitude(bus.b, div_signed);
  assign div_load     = accept && ((bus.op == OP_DIV) || (bus.op == OP_DIVU)) && (bus.b != '0);
  assign div_step     = (state == ST_DIV) && !bus.flush;

  hilo_divider u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .quo      (div_quo),
    .rem      (div_rem),
    .done     (div_done)
  );

  // Quotient takes the XOR of operand signs, remainder the dividend's sign.
  // The 0x80000000 / -1 overflow negates 0x80000000 onto itself.
  assign quo_fin = sign_q ? -div_quo : div_quo;
  assign rem_fin = sign_r ? -div_rem : div_rem;

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are
  // then correct for both MULT and MULTU.
  assign ext_a   = mul_signed ? {{DATA_W{mul_a[DATA_W-1]}}, mul_a} : {{DATA_W{1'b0}}, mul_a};
  assign ext_b   = mul_signed ? {{DATA_W{mul_b[DATA_W-1]}}, mul_b} : {{DATA_W{1'b0}}, mul_b};
  assign product = ext_a * ext_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      busy_q     <= 1'b0;
      we_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_signed <= 1'b0;
      sign_q     <= 1'b0;
      sign_r     <= 1'b0;
    end else begin
      we_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            case (bus.op)
              OP_MTHI: begin
                hi_q <= bus.a;
                lo_q <= bus.lo_cur;
                we_q <= 1'b1;
              end
              OP_MTLO: begin
                hi_q <= bus.hi_cur;
                lo_q <= bus.a;
                we_q <= 1'b1;
              end
              OP_MULT, OP_MULTU: begin
                mul_a      <= bus.a;
                mul_b      <= bus.b;
                mul_signed <= (bus.op == OP_MULT);
                state      <= ST_MUL;
                busy_q     <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                if (bus.b == '0) begin
                  hi_q <= bus.a;
                  lo_q <= '1;
                  we_q <= 1'b1;
                end else begin
                  sign_q <= div_signed && (bus.a[DATA_W-1] ^ bus.b[DATA_W-1]);
                  sign_r <= div_signed && bus.a[DATA_W-1];
                  state  <= ST_DIV;
                  busy_q <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          if (!bus.flush) begin
            hi_q <= product[2*DATA_W-1:DATA_W];
            lo_q <= product[DATA_W-1:0];
            we_q <= 1'b1;
          end
        end
        ST_DIV: begin
          if (bus.flush) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else if (div_done) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            hi_q   <= rem_fin;
            lo_q   <= quo_fin;
            we_q   <= 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.hilo_we = we_q;
  assign bus.hi_o    = hi_q;
  assign bus.lo_o    = lo_q;

endmodule

// File: doc/hilo_ctrl.md
# hilo_ctrl

Multiply/divide sequencer that owns all writes into the HI/LO register pair of the pipelined CPU. Accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO request at a time from the execute stage. Computes the 64-bit result, with division done iteratively. Presents the result to the HI/LO register as a single one-cycle write strobe and stalls the pipeline while an operation is in flight.

## Interface
- `DIV_CYCLES`, 32: iterations of the restoring divider; fixed to operand width.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: request valid; sampled only in IDLE.
- `op` in 3: operation code. NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6; 7 reserved.
- `a` in 32: rs operand (multiplicand, dividend, or MTHI/MTLO data).
- `b` in 32: rt operand (multiplier or divisor).
- `hi_cur` in 32: current HI register value.
- `lo_cur` in 32: current LO register value.
- `flush` in 1: pipeline flush/exception; cancels the in-flight op.
- `busy` out 1: stall request to the pipeline.
- `hilo_we` out 1: one-cycle write strobe to the HI/LO register.
- `hi_o` out 32: HI write data.
- `lo_o` out 32: LO write data.

## Operation
- FSM states: IDLE, MUL, DIV.
- IDLE, accepting a request:
  - Accept when `start`=1, `op` ∈ 1..6, and `flush`=0.
  - `op`=0, `op`=7, or `start`=0: no action.
- MTHI/MTLO: no state change.
  - Registers `hi_o`=a, `lo_o`=lo_cur for MTHI.
  - Registers `hi_o`=hi_cur, `lo_o`=a for MTLO.
  - `hilo_we`=1 next cycle.
- MULT/MULTU: go to MUL, latching operands.
  - In MUL, register the 64-bit product (signed or unsigned per op): HI=product[63:32], LO=product[31:0].
  - Pulse `hilo_we`, return to IDLE.
- DIV/DIVU, `b`≠0: go to DIV.
  - Load |a| and |b| (raw values for DIVU). Remember sign_q = a[31]^b[31] and sign_r = a[31] (both 0 for DIVU).
  - Counter loads DIV_CYCLES-1. Each DIV cycle performs one restoring shift/subtract step.
  - When the counter reaches 0: apply signs (negate quotient if sign_q, remainder if sign_r), set LO=quotient and HI=remainder, pulse `hilo_we`, return to IDLE.
- DIV/DIVU, `b`=0: no DIV state. Registers HI=a and LO=32'hFFFFFFFF, and pulses `hilo_we` next cycle.
- Overflow case 0x80000000 / -1 (signed): LO=0x80000000, HI=0. This falls out of magnitude arithmetic; no special case.
- `flush` in MUL or DIV: next state IDLE, no write, datapath contents don't-care.
- `flush` has no effect on a `hilo_we` pulse already registered. A pulse that is high in the flush cycle still writes.
- `flush` together with `start` in IDLE: flush wins and the request is dropped.
- `start` while busy is ignored. The pipeline holds the instruction because `busy` is high.
- Reset, asynchronous at any time: state IDLE, counter 0, `busy`=0, `hilo_we`=0, `hi_o`=0, `lo_o`=0. An in-flight op is lost.

## Timing
- All outputs registered. `busy` = (state ≠ IDLE), registered with the state.
- Latency from the accepting edge T (hilo_we high in the cycle that starts at the given edge):
  - MTHI/MTLO and divide-by-zero: T+1.
  - MULT/MULTU: T+2 (MUL for one cycle).
  - DIV/DIVU: T+1+DIV_CYCLES = T+33.
- `busy` high:
  - MUL: the cycle after T only.
  - DIV: cycles T+1 … T+32.
  - Deasserts in the same cycle `hilo_we` rises.
- `hilo_we` is high for exactly one cycle per completed op. `hi_o`/`lo_o` hold their last values otherwise.
- A new request is accepted in the cycle `hilo_we` is high (back-to-back).

## Structure
- Package `hilo_pkg`: op code localparams (OP_NONE…OP_MTLO), state encodings, DIV_CYCLES, data width 32.
- Sub-module `hilo_divider`: restoring divider datapath.
  - Inputs: load, step, magnitudes.
  - Outputs: quotient and remainder registers.
  - Includes the iteration counter and done flag.
- The FSM, multiply, sign handling, and output registers stay in `hilo_ctrl`.

## Test plan
- MULT a=0xFFFFFFFE (-2), b=3: hilo_we at T+2 with HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands: HI=0x00000002, LO=0xFFFFFFFA. busy high one cycle.
- DIV a=-7 (0xFFFFFFF9), b=2: busy 32 cycles, hilo_we at T+33, LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=100, b=7: LO=14, HI=2.
- DIV a=0x80000000, b=0xFFFFFFFF: LO=0x80000000, HI=0. DIVU b=0, a=5: T+1 write, HI=5, LO=0xFFFFFFFF, busy never high.
- MTHI a=0x12345678 with hi_cur=1, lo_cur=0xAAAA: T+1 write, HI=0x12345678, LO=0xAAAA. MTLO mirrors this.
- flush at T+10 of a DIV: busy low at T+11, no hilo_we through T+40. start with flush in the same cycle: ignored. start while busy: ignored.
- rst low at T+5 of a DIV: all outputs 0 immediately (asynchronous). After release, a MULTU 3×4 gives LO=12, HI=0 at +2.
